// File: rtl/unpack_pkg.sv
// Shared constants and entry type for the 256-to-32 unpacking buffer.
package unpack_pkg;

  localparam int IN_WIDTH  = 256;
  localparam int OUT_WIDTH = 32;
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
  localparam int BEAT_W    = $clog2(RATIO);

  typedef struct packed {
    logic                last;
    logic [IN_WIDTH-1:0] data;
  } entry_t;

  // Word viewed as an array of output lanes; lane 0 is the least significant slice.
  typedef logic [RATIO-1:0][OUT_WIDTH-1:0] lanes_t;

endpackage

// File: rtl/unpack_word_buf.sv
// Two-entry word buffer: pointers, occupancy and push acceptance.
module unpack_word_buf
  import unpack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push_valid,
  input  entry_t     push_entry,
  output logic       push_ready,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       do_push;
  logic       do_pop;

  // Acceptance looks only at registered occupancy, so a full buffer refuses even while popping.
  always_comb begin
    push_ready = (count_q < 2'd2);
    do_push    = push_valid && push_ready && !clr;
    do_pop     = pop && (count_q != 2'd0) && !clr;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only observed when count says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ram_256to32_unpack.sv
// 256-bit word to 32-bit beat unpacker with a two-word buffer.
// Define UNPACK_MSB_FIRST_EN to emit the most significant lane first.
module ram_256to32_unpack
  import unpack_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           level
);

  logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
  logic [BEAT_W-1:0] lane_sel;
  logic [1:0]        count;
  entry_t            in_entry;
  entry_t            head;
  lanes_t            head_lanes;
  logic              beat_pop;
  logic              final_beat;
  logic              word_pop;

  assign in_entry = {in_last, in_data};

  unpack_word_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .push_valid (in_valid),
    .push_entry (in_entry),
    .push_ready (in_ready),
    .pop        (word_pop),
    .head       (head),
    .count      (count)
  );

  always_comb begin
    out_valid  = (count != 2'd0);
    beat_pop   = out_valid && out_ready;
    final_beat = (beat_idx_q == BEAT_W'(RATIO - 1));
    word_pop   = beat_pop && final_beat;
  end

  always_comb begin
    beat_idx_d = beat_idx_q;
    if (clr) begin
      beat_idx_d = '0;
    end else if (beat_pop) begin
      beat_idx_d = beat_idx_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx_q <= '0;
    end else begin
      beat_idx_q <= beat_idx_d;
    end
  end

`ifdef UNPACK_MSB_FIRST_EN
  assign lane_sel = BEAT_W'(RATIO - 1) - beat_idx_q;
`else
  assign lane_sel = beat_idx_q;
`endif

  // Last beat of a tagged word is the eighth emitted regardless of lane order.
  always_comb begin
    head_lanes = head.data;
    out_data   = head_lanes[lane_sel];
    out_last   = out_valid && head.last && final_beat;
    level      = count;
  end

endmodule

// File: tb/tb_ram_256to32_unpack.sv
// Self-checking bench for ram_256to32_unpack: beat-queue model plus directed literal checks.
module tb_ram_256to32_unpack;
  import unpack_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr = 1'b0;
  logic [IN_WIDTH-1:0]  in_data = '0;
  logic                 in_last = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [1:0]           level;

  ram_256to32_unpack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    logic                 last;
  } beat_t;

  beat_t model_q[$];
  int    check_count = 0;
  int    pass_count = 0;
  int    pop_count = 0;
  int    last_count = 0;
  int    last_beat_num = 0;

  function automatic int lane_of(int k);
`ifdef UNPACK_MSB_FIRST_EN
    return RATIO - 1 - k;
`else
    return k;
`endif
  endfunction

  // Lane k of the word holds base + k.
  function automatic logic [IN_WIDTH-1:0] make_word(logic [31:0] base);
    logic [IN_WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < RATIO; k++) w[k*OUT_WIDTH +: OUT_WIDTH] = base + 32'(k);
    return w;
  endfunction

  function automatic logic [31:0] exp_beat(logic [31:0] base, int k);
    return base + 32'(lane_of(k));
  endfunction

  function automatic int model_level();
    return (model_q.size() + RATIO - 1) / RATIO;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(logic iv, logic il, logic [IN_WIDTH-1:0] d, logic ordy, logic cl);
    in_valid  = iv;
    in_last   = il;
    in_data   = d;
    out_ready = ordy;
    clr       = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) tick();
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Model: a word occupies buffer space while any of its beats remain queued.
  always @(posedge clk) begin : model_update
    int    lvl;
    beat_t b;
    if (!rst_n || clr) begin
      model_q.delete();
    end else begin
      lvl = model_level();
      if (out_ready && model_q.size() > 0) begin
        b = model_q.pop_front();
        pop_count++;
        if (b.last) begin
          last_count++;
          last_beat_num = pop_count;
        end
      end
      if (in_valid && lvl < 2) begin
        for (int k = 0; k < RATIO; k++) begin
          b.data = in_data[lane_of(k)*OUT_WIDTH +: OUT_WIDTH];
          b.last = in_last && (k == RATIO - 1);
          model_q.push_back(b);
        end
      end
    end
  end

  always @(negedge rst_n) model_q.delete();

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmp_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      checkOutput("cmp_level", 32'(level), 32'(model_level()));
      checkOutput("cmp_in_ready", 32'(in_ready), 32'(model_level() < 2));
      if (model_q.size() > 0) begin
        checkOutput("cmp_out_data", out_data, model_q[0].data);
        checkOutput("cmp_out_last", 32'(out_last), 32'(model_q[0].last));
      end
    end
  end

  initial begin
    logic [31:0] bases [4];
    int          idx;
    logic        acc;
    logic        pending;

    // Reset state
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Test 1: single word, lane k = k
    applyStimulus(1'b1, 1'b0, make_word(32'd0), 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < RATIO; k++) begin
      checkOutput("t1_beat_data", out_data, exp_beat(32'd0, k));
      checkOutput("t1_beat_last", 32'(out_last), 32'd0);
      tick();
    end
    checkOutput("t1_level_end", 32'(level), 32'd0);
    checkOutput("t1_valid_end", 32'(out_valid), 32'd0);

    // Test 2: four back-to-back words, last tagged on word 4
    pop_count = 0;
    last_count = 0;
    last_beat_num = 0;
    bases[0] = 32'h100; bases[1] = 32'h200; bases[2] = 32'h300; bases[3] = 32'h400;
    idx = 0;
    for (int c = 0; c < 100 && idx < 4; c++) begin
      applyStimulus(1'b1, idx == 3, make_word(bases[idx]), 1'b1, 1'b0);
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    checkOutput("t2_all_pushed", 32'(idx), 32'd4);
    drain();
    checkOutput("t2_beats", 32'(pop_count), 32'd32);
    checkOutput("t2_last_count", 32'(last_count), 32'd1);
    checkOutput("t2_last_beat_num", 32'(last_beat_num), 32'd32);

    // Test 3: stalls with two words buffered
    applyStimulus(1'b1, 1'b0, make_word(32'h1000), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, make_word(32'h2000), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, make_word(32'h3000), 1'b1, 1'b0);
    checkOutput("t3_first_data", out_data, exp_beat(32'h1000, 0));
    checkOutput("t3_full_in_ready", 32'(in_ready), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, make_word(32'h3000), 1'b0, 1'b0);
    checkOutput("t3_after_pop", out_data, exp_beat(32'h1000, 1));
    tick();
    checkOutput("t3_stall1", out_data, exp_beat(32'h1000, 1));
    tick();
    checkOutput("t3_stall2", out_data, exp_beat(32'h1000, 1));
    pending = 1'b1;
    for (int c = 0; c < 200 && pending; c++) begin
      applyStimulus(1'b1, 1'b0, make_word(32'h3000), (c % 4 == 0) || (c % 4 == 3), 1'b0);
      acc = in_ready;
      tick();
      if (acc) pending = 1'b0;
    end
    checkOutput("t3_third_pushed", 32'(pending), 32'd0);
    drain();

    // Test 4: full buffer refuses a push in the cycle its head word pops
    applyStimulus(1'b1, 1'b0, make_word(32'h4000), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, make_word(32'h5000), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, make_word(32'h6000), 1'b1, 1'b0);
    for (int c = 0; c < RATIO - 1; c++) tick();
    checkOutput("t4_level_before", 32'(level), 32'd2);
    checkOutput("t4_ready_before", 32'(in_ready), 32'd0);
    tick();
    checkOutput("t4_level_pop", 32'(level), 32'd1);
    checkOutput("t4_ready_pop", 32'(in_ready), 32'd1);
    tick();
    checkOutput("t4_level_push", 32'(level), 32'd2);
    drain();

    // Test 5: clear mid-word with a push presented
    applyStimulus(1'b1, 1'b0, make_word(32'h7000), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, make_word(32'h8000), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    applyStimulus(1'b1, 1'b0, make_word(32'h9000), 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("t5_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_level", 32'(level), 32'd0);
    checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, make_word(32'hA000), 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t5_restart_data", out_data, exp_beat(32'hA000, 0));
    drain();

    // Test 6: asynchronous reset mid-stream
    applyStimulus(1'b1, 1'b0, make_word(32'hB000), 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, make_word(32'hC000), 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_level", 32'(level), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, make_word(32'hD000), 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t6_first_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_first_data", out_data, exp_beat(32'hD000, 0));
    drain();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
